// File: rtl/lbus_crypto_slave.sv
// Cipher-side endpoint of the SAKURA-G local bus.
// It decodes the address/data word stream from the lbus master, holds the
// key and plaintext registers, and starts the cipher core. It also captures
// the core result and drives the OpenADC capture trigger.
module lbus_crypto_slave #(
  parameter logic [15:0] VERSION   = 16'h0001,
  parameter logic [15:0] ADDR_CTRL = 16'h0002,
  parameter logic [15:0] ADDR_KEY  = 16'h0100,
  parameter logic [15:0] ADDR_TEXT = 16'h0140,
  parameter logic [15:0] ADDR_RES  = 16'h0180
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic [15:0]  lbus_di_a,
  input  logic         lbus_wrn,
  input  logic         lbus_rdn,
  output logic [15:0]  lbus_do,
  output logic [127:0] key_o,
  output logic [127:0] text_o,
  output logic         start_o,
  output logic         core_rst_o,
  input  logic         busy_i,
  input  logic         done_i,
  input  logic [127:0] result_i,
  output logic         trigger_o
);

  localparam logic [15:0] ADDR_VER = 16'hFFFC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADDR = 1'b1;

  logic [0:0]   state;
  logic [15:0]  addr;
  logic [127:0] result_q;
  logic         done_flag;
  logic [15:0]  rd_mux;

  logic wr_req;
  logic rd_req;
  logic data_wr;
  logic data_rd;
  logic ctrl_wr;
  logic start_go;
  logic srst_go;

  // The three register banks are 8-word aligned, so the upper 13 address
  // bits select the bank and the low 3 bits select the word.
  function automatic logic in_bank(input logic [15:0] a, input logic [15:0] base);
    return a[15:3] == base[15:3];
  endfunction

  // Word 0 sits in the most significant slice of the 128-bit vector.
  function automatic logic [15:0] word_of(input logic [127:0] vec, input logic [2:0] idx);
    return vec[{~idx, 4'b0000} +: 16];
  endfunction

  assign wr_req  = ~lbus_wrn;
  assign rd_req  = ~lbus_rdn;
  assign data_wr = (state == ST_ADDR) && wr_req;
  // A write strobe takes precedence over a simultaneous read strobe.
  assign data_rd = (state == ST_ADDR) && rd_req && !wr_req;
  assign ctrl_wr = data_wr && (addr == ADDR_CTRL);
  // Soft reset wins over start. A start is refused while the core is busy
  // or a previous trace is still being captured.
  assign srst_go  = ctrl_wr && lbus_di_a[2];
  assign start_go = ctrl_wr && lbus_di_a[0] && !lbus_di_a[2] && !busy_i && !trigger_o;

  // Two-phase word decoder: first word is an address, second is data or a read
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= ST_IDLE;
      addr  <= 16'h0000;
    end else if (state == ST_IDLE) begin
      if (wr_req) begin
        addr  <= lbus_di_a;
        state <= ST_ADDR;
      end
    end else if (wr_req || rd_req) begin
      state <= ST_IDLE;
    end
  end

  // Key and plaintext slice writes; accepted regardless of core state
  always_ff @(posedge clk) begin
    if (reset_i) begin
      key_o  <= 128'h0;
      text_o <= 128'h0;
    end else if (data_wr) begin
      if (in_bank(addr, ADDR_KEY))
        key_o[{~addr[2:0], 4'b0000} +: 16] <= lbus_di_a;
      if (in_bank(addr, ADDR_TEXT))
        text_o[{~addr[2:0], 4'b0000} +: 16] <= lbus_di_a;
    end
  end

  // Result capture and completion flag
  always_ff @(posedge clk) begin
    if (reset_i) begin
      result_q  <= 128'h0;
      done_flag <= 1'b0;
    end else begin
      if (done_i)
        result_q <= result_i;
      if (srst_go)
        done_flag <= 1'b0;
      else if (done_i)
        done_flag <= 1'b1;
      else if (start_go)
        done_flag <= 1'b0;
    end
  end

  // Core control pulses and capture trigger
  always_ff @(posedge clk) begin
    if (reset_i) begin
      start_o    <= 1'b0;
      core_rst_o <= 1'b0;
      trigger_o  <= 1'b0;
    end else begin
      start_o    <= start_go;
      core_rst_o <= srst_go;
      if (srst_go)
        trigger_o <= 1'b0;
      else if (start_go)
        trigger_o <= 1'b1;
      else if (done_i)
        trigger_o <= 1'b0;
    end
  end

  // Read-data multiplexer; unmapped addresses read as zero
  always_comb begin
    rd_mux = 16'h0000;
    if (addr == ADDR_VER)
      rd_mux = VERSION;
    else if (addr == ADDR_CTRL)
      rd_mux = {14'b0, busy_i, done_flag};
    else if (in_bank(addr, ADDR_KEY))
      rd_mux = word_of(key_o, addr[2:0]);
    else if (in_bank(addr, ADDR_TEXT))
      rd_mux = word_of(text_o, addr[2:0]);
    else if (in_bank(addr, ADDR_RES))
      rd_mux = word_of(result_q, addr[2:0]);
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk) begin
    if (reset_i)
      lbus_do <= 16'h0000;
    else if (data_rd)
      lbus_do <= rd_mux;
  end

endmodule

// File: tb/tb_lbus_crypto_slave.sv
// Directed-vector bench for lbus_crypto_slave. Inputs change on the falling
// edge, and outputs are sampled on the falling edge after the active edge.
module tb_lbus_crypto_slave;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [15:0]  lbus_di_a;
  logic         lbus_wrn;
  logic         lbus_rdn;
  logic [15:0]  lbus_do;
  logic [127:0] key_o;
  logic [127:0] text_o;
  logic         start_o;
  logic         core_rst_o;
  logic         busy_i;
  logic         done_i;
  logic [127:0] result_i;
  logic         trigger_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] KEY_EXP  = 128'h0011_0022_0033_0044_0055_0066_0077_0088;
  localparam logic [127:0] TEXT_EXP = 128'hA000_A001_A002_A003_A004_A005_A006_A007;
  localparam logic [127:0] RES_VAL  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;

  always #5 clk = ~clk;

  lbus_crypto_slave dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .lbus_di_a  (lbus_di_a),
    .lbus_wrn   (lbus_wrn),
    .lbus_rdn   (lbus_rdn),
    .lbus_do    (lbus_do),
    .key_o      (key_o),
    .text_o     (text_o),
    .start_o    (start_o),
    .core_rst_o (core_rst_o),
    .busy_i     (busy_i),
    .done_i     (done_i),
    .result_i   (result_i),
    .trigger_o  (trigger_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One strobed word; returns on the falling edge just after it was taken.
  task automatic bus_word(input logic [15:0] w);
    @(negedge clk);
    lbus_wrn  = 1'b0;
    lbus_di_a = w;
    @(negedge clk);
    lbus_wrn  = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus_word(a);
    bus_word(d);
  endtask

  // Address word, then one rdn-low cycle; lbus_do is valid on return.
  task automatic bus_read(input logic [15:0] a);
    bus_word(a);
    @(negedge clk);
    lbus_rdn = 1'b0;
    @(negedge clk);
    lbus_rdn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i   = 1'b1;
    lbus_di_a = 16'h0;
    lbus_wrn  = 1'b1;
    lbus_rdn  = 1'b1;
    busy_i    = 1'b0;
    done_i    = 1'b0;
    result_i  = 128'h0;
    repeat (3) @(negedge clk);
    check("rst_do",   lbus_do,    0);
    check("rst_key",  key_o,      0);
    check("rst_text", text_o,     0);
    check("rst_ctl",  {start_o, core_rst_o, trigger_o}, 0);
    reset_i = 1'b0;
    bus_read(16'h0002);
    check("rst_status", lbus_do, 16'h0000);

    // Key and plaintext loading
    for (int i = 0; i < 8; i++)
      bus_write(16'h0100 + 16'(i), 16'(16'h0011 * (i + 1)));
    check("key_all", key_o, KEY_EXP);
    for (int i = 0; i < 8; i++)
      bus_write(16'h0140 + 16'(i), 16'hA000 + 16'(i));
    check("text_all", text_o, TEXT_EXP);
    bus_read(16'h0103);
    check("key_rd3", lbus_do, 16'h0044);

    // Accepted start, then completion
    bus_write(16'h0002, 16'h0001);
    check("start_hi",   start_o,   1);
    check("trig_rise",  trigger_o, 1);
    busy_i = 1'b1;
    @(negedge clk);
    check("start_1cyc", start_o,   0);
    check("trig_hold",  trigger_o, 1);
    done_i   = 1'b1;
    result_i = RES_VAL;
    @(negedge clk);
    done_i = 1'b0;
    busy_i = 1'b0;
    check("trig_fall", trigger_o, 0);
    bus_read(16'h0180);
    check("res_w0", lbus_do, 16'hDEAD);
    bus_read(16'h0187);
    check("res_w7", lbus_do, 16'h2D3C);
    bus_write(16'h0180, 16'h1111);
    bus_read(16'h0180);
    check("res_ro", lbus_do, 16'hDEAD);

    // Status, version, unmapped
    bus_read(16'h0002);
    check("status_done", lbus_do, 16'h0001);
    bus_read(16'hFFFC);
    check("version", lbus_do, 16'h0001);
    bus_read(16'h0500);
    check("unmapped", lbus_do, 16'h0000);

    // Start refused while busy
    busy_i = 1'b1;
    bus_write(16'h0002, 16'h0001);
    check("blk_start", start_o,   0);
    check("blk_trig",  trigger_o, 0);
    bus_read(16'h0002);
    check("status_busy", lbus_do, 16'h0003);
    busy_i = 1'b0;

    // rdn in IDLE leaves lbus_do alone and does not disturb the decoder
    @(negedge clk);
    lbus_rdn = 1'b0;
    @(negedge clk);
    lbus_rdn = 1'b1;
    check("idle_rdn", lbus_do, 16'h0003);
    bus_read(16'hFFFC);
    check("idle_rdn_ver", lbus_do, 16'h0001);

    // wrn and rdn together in ADDR: data write only
    bus_word(16'h0140);
    @(negedge clk);
    lbus_wrn  = 1'b0;
    lbus_rdn  = 1'b0;
    lbus_di_a = 16'h5555;
    @(negedge clk);
    lbus_wrn = 1'b1;
    lbus_rdn = 1'b1;
    check("both_no_rd", lbus_do, 16'h0001);
    check("both_wr", text_o[127:112], 16'h5555);
    bus_read(16'h0140);
    check("both_rdback", lbus_do, 16'h5555);

    // Start collides with done while trigger is high: dropped
    bus_write(16'h0002, 16'h0001);
    check("start2", start_o, 1);
    bus_word(16'h0002);
    @(negedge clk);
    lbus_wrn  = 1'b0;
    lbus_di_a = 16'h0001;
    done_i    = 1'b1;
    @(negedge clk);
    lbus_wrn = 1'b1;
    done_i   = 1'b0;
    check("coll_start", start_o,   0);
    check("coll_trig",  trigger_o, 0);
    bus_read(16'h0002);
    check("coll_status", lbus_do, 16'h0001);

    // Accepted start clears done_flag; soft reset clears trigger
    bus_write(16'h0002, 16'h0001);
    check("start3", start_o, 1);
    bus_read(16'h0002);
    check("start_clr_done", lbus_do, 16'h0000);
    bus_write(16'h0002, 16'h0005);
    check("srst_pulse", core_rst_o, 1);
    check("srst_trig",  trigger_o,  0);
    @(negedge clk);
    check("srst_1cyc", core_rst_o, 0);

    // Soft reset wins over start with the trigger idle
    bus_write(16'h0002, 16'h0005);
    check("prio_rst",   core_rst_o, 1);
    check("prio_start", start_o,    0);
    check("prio_trig",  trigger_o,  0);
    bus_read(16'h0002);
    check("srst_status", lbus_do, 16'h0000);

    // Hard reset between address and data words
    bus_word(16'h0100);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_key", key_o, 0);
    bus_word(16'h1234);
    @(negedge clk);
    lbus_rdn = 1'b0;
    @(negedge clk);
    lbus_rdn = 1'b1;
    check("mid_rd", lbus_do, 16'h0000);
    check("mid_key2", key_o, 0);
    bus_read(16'hFFFC);
    check("mid_ver", lbus_do, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbus_crypto_slave.md
Name: lbus_crypto_slave

Overview:
- Cryptographic-module-side endpoint of the SAKURA-G local bus.
- Consumes the address/data word stream and the wrn/rdn strobes that the controller-side lbus master drives. Returns read data on lbus_do.
- Holds the key/plaintext register file and starts the cipher core. Captures its result and drives the capture trigger seen by the OpenADC.
- Sits between the lbus pins and the AES/cipher core on the main FPGA.

Parameters:
- VERSION, 16'h0001, value returned when reading address 0xFFFC.
- ADDR_CTRL, 16'h0002, control/status register address.
- ADDR_KEY, 16'h0100, base of 8 key words (0x0100-0x0107).
- ADDR_TEXT, 16'h0140, base of 8 plaintext words.
- ADDR_RES, 16'h0180, base of 8 read-only result words.

Ports:
- clk, in, 1, lbus clock (lbus_clkn domain); the only clock.
- reset_i, in, 1, synchronous active-high reset.
- lbus_di_a, in, 16, address or write-data word.
- lbus_wrn, in, 1, active-low word strobe, one word per low cycle.
- lbus_rdn, in, 1, active-low read request.
- lbus_do, out, 16, read data.
- key_o, out, 128, key to core; word 0 maps to [127:112].
- text_o, out, 128, plaintext to core; same word order as key_o.
- start_o, out, 1, one-cycle start pulse to core.
- core_rst_o, out, 1, one-cycle soft reset to core.
- busy_i, in, 1, core busy.
- done_i, in, 1, one-cycle completion pulse from core.
- result_i, in, 128, core output, valid on done_i.
- trigger_o, out, 1, capture trigger to OpenADC.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk.
- Reset values:
  - lbus_do = 0, key_o = 0, text_o = 0.
  - result register = 0, start_o = 0, core_rst_o = 0, trigger_o = 0.
  - done_flag = 0.
  - Phase FSM = IDLE, address latch = 0.
- Phase FSM, with states IDLE and ADDR:
  - IDLE, wrn = 0: latch lbus_di_a as address, go to ADDR.
  - ADDR, wrn = 0: lbus_di_a is write data to the latched address; go to IDLE.
  - ADDR, rdn = 0 (wrn = 1): perform a read of the latched address; go to IDLE.
  - IDLE, rdn = 0: ignored, lbus_do unchanged.
- Simultaneous wrn = 0 and rdn = 0: the write path wins and rdn is ignored in that cycle.
- Read latency: lbus_do is registered and takes the new value on the clock edge after the rdn-low cycle. It holds that value until the next read.
- Reads of unmapped addresses return 0x0000. Writes to unmapped or read-only addresses have no effect.
- Control register at ADDR_CTRL, write side:
  - bit0 = 1: start_o pulses for 1 cycle the cycle after the data word, only if busy_i = 0 and trigger_o = 0. Otherwise the start is dropped.
  - bit2 = 1: core_rst_o pulses for 1 cycle; done_flag and trigger_o are cleared.
  - bit0 and bit2 both set: reset takes priority and start is dropped.
- Control register at ADDR_CTRL, read side: {14'b0, busy_i, done_flag}.
- Key and text writes update the addressed 16-bit slice immediately. Writes are accepted even while busy; the core is responsible for latching its inputs at start.
- Trigger:
  - trigger_o rises in the same cycle as start_o.
  - trigger_o falls the cycle after done_i.
  - done_i and a new start in the same cycle: the start is dropped, because trigger_o is still high.
- Result capture: on done_i, result_i is copied to the result register and done_flag is set. done_flag clears on the next accepted start or on a soft reset.
- reset_i mid-transaction: the FSM returns to IDLE and any half-received address is discarded.

Test Plan:
- Write the key: 8 address/data pairs to 0x0100-0x0107 with data 0x0011..0x0077, 0x0088 → key_o = 128'h0011_0022_..._0088.
- Start: write 0x0001 to 0x0002 with busy_i = 0 → start_o high exactly 1 cycle and trigger_o rises in the same cycle. Then pulse done_i with result_i = 128'hDEAD_...; trigger_o falls the next cycle, and reading 0x0180 gives 0xDEAD one cycle after rdn.
- Blocked start: write 0x0001 to 0x0002 while busy_i = 1 → no start_o pulse and trigger_o stays 0.
- Status and version read: read 0x0002 after done → lbus_do = 0x0001. Read 0xFFFC → lbus_do = VERSION. Read 0x0500 → 0x0000.
- Protocol edges:
  - rdn low in IDLE → lbus_do unchanged.
  - wrn and rdn both low in ADDR → treated as a data write, with no read.
  - Soft reset 0x0005 → core_rst_o pulses, start_o stays 0, done_flag = 0.
- Reset mid-transaction: assert reset_i between the address and data words, then send one word 0x1234 followed by a rdn read → 0x1234 is taken as an address, and the read returns 0x0000.
